wam_score_disp: RTL and testbench



---
 rtl/wam_score_disp.sv | 179 +++++++++++++++++
 tb/tb_wam_score_disp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wam_score_disp.sv
// Whac-A-Mole score/hardness display: sequential binary-to-BCD,
// leading-zero blanking and a multiplexed seven-segment scan.
module wam_score_disp #(
   parameter int SCORE_W   = 12,
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1024,
   parameter int FLASH_LEN = 8
) (
   input  logic                  clk_19,
   input  logic                  rst,
   input  logic [SCORE_W-1:0]    score,
   input  logic [3:0]            hrdn,
   input  logic                  flash,
   output logic [6:0]            seg,
   output logic [DIGITS:0]       an,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  ovf
);

   function automatic logic [31:0] max_val(input int d);
      logic [31:0] v;
      v = 32'd1;
      for (int i = 0; i < d; i++) v = v * 32'd10;
      return v - 32'd1;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Each 3 binary bits need at most one decimal digit.
   localparam int NB   = ((SCORE_W + 2) / 3 > DIGITS) ? (SCORE_W + 2) / 3 : DIGITS;
   localparam int CW   = $clog2(SCORE_W + 1);
   localparam int SW   = $clog2(SCAN_DIV);
   localparam int PW   = $clog2(DIGITS + 1);
   localparam int FW   = $clog2(FLASH_LEN + 1);
   localparam int NA   = DIGITS + 1;
   localparam int TW   = 4 * NB + SCORE_W;
   localparam logic [31:0] MAXV = max_val(DIGITS);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} cv_t;

   cv_t                 state;
   logic [SCORE_W-1:0]  last;
   logic [SCORE_W-1:0]  bin;
   logic [4*NB-1:0]     acc;
   logic [4*NB-1:0]     acc_adj;
   logic [TW-1:0]       nxt;
   logic [CW-1:0]       cnt;

   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < NB; i++)
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      nxt = {acc_adj, bin} << 1;
   end

   always_ff @(posedge clk_19) begin
      if (rst) begin
         state <= IDLE;
         last  <= '0;
         bin   <= '0;
         acc   <= '0;
         cnt   <= '0;
         bcd   <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (score != last) begin
                  bin   <= score;
                  last  <= score;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= nxt[TW-1:SCORE_W];
               bin <= nxt[SCORE_W-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(SCORE_W - 1)) state <= DONE;
            end
            DONE: begin
               // Overflow judged on the binary value, never on BCD.
               if (32'(last) > MAXV) begin
                  bcd <= {DIGITS{4'h9}};
                  ovf <= 1'b1;
               end else begin
                  bcd <= acc[4*DIGITS-1:0];
                  ovf <= 1'b0;
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic          flash_q;
   logic [FW-1:0] fcnt;

   always_ff @(posedge clk_19) begin
      if (rst) begin
         flash_q <= 1'b0;
         fcnt    <= '0;
      end else begin
         flash_q <= flash;
         if (flash && !flash_q)
            fcnt <= FW'(FLASH_LEN);
         else if (fcnt != '0)
            fcnt <= fcnt - 1'b1;
      end
   end

   logic [SW-1:0] scnt;
   logic [PW-1:0] pos;
   logic [3:0]    dig;
   logic          blank;
   logic [6:0]    seg_n;
   logic [NA-1:0] an_n;

   always_comb begin
      dig   = hrdn;
      blank = (fcnt != '0);
      for (int k = 0; k < DIGITS; k++) begin
         if (pos == PW'(k)) begin
            dig   = bcd[4*k +: 4];
            blank = (k != 0) && !ovf && ((bcd >> (4*k)) == '0);
         end
      end
      seg_n = blank ? 7'h7F : glyph(dig);
      an_n  = ~(NA'(1) << pos);
   end

   // an and seg update together so a digit never shows its neighbour's glyph.
   always_ff @(posedge clk_19) begin
      if (rst) begin
         scnt <= '0;
         pos  <= '0;
         an   <= '1;
         seg  <= 7'h7F;
      end else begin
         an  <= an_n;
         seg <= seg_n;
         if (scnt == SW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            pos  <= (pos == PW'(DIGITS)) ? '0 : pos + 1'b1;
         end else begin
            scnt <= scnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wam_score_disp.sv
// Directed bench for wam_score_disp: three instances cover
// conversion, overflow, scan order and hardness flashing.
module tb_wam_score_disp;

   logic clk_19 = 1'b0;
   always #5 clk_19 = ~clk_19;

   logic rst;

   logic [11:0] score_a, score_b, score_c;
   logic [3:0]  hrdn_a, hrdn_b, hrdn_c;
   logic        flash_a, flash_b, flash_c;
   logic [6:0]  seg_a, seg_b, seg_c;
   logic [4:0]  an_a;
   logic [3:0]  an_b;
   logic [1:0]  an_c;
   logic [15:0] bcd_a;
   logic [11:0] bcd_b;
   logic [3:0]  bcd_c;
   logic        busy_a, busy_b, busy_c;
   logic        ovf_a, ovf_b, ovf_c;

   int tests = 0;
   int fails = 0;

   wam_score_disp #(.SCORE_W(12), .DIGITS(4), .SCAN_DIV(4), .FLASH_LEN(8)) u_a (
      .clk_19(clk_19), .rst(rst), .score(score_a), .hrdn(hrdn_a),
      .flash(flash_a), .seg(seg_a), .an(an_a), .bcd(bcd_a),
      .busy(busy_a), .ovf(ovf_a));

   wam_score_disp #(.SCORE_W(12), .DIGITS(3), .SCAN_DIV(4), .FLASH_LEN(8)) u_b (
      .clk_19(clk_19), .rst(rst), .score(score_b), .hrdn(hrdn_b),
      .flash(flash_b), .seg(seg_b), .an(an_b), .bcd(bcd_b),
      .busy(busy_b), .ovf(ovf_b));

   wam_score_disp #(.SCORE_W(12), .DIGITS(1), .SCAN_DIV(64), .FLASH_LEN(8)) u_c (
      .clk_19(clk_19), .rst(rst), .score(score_c), .hrdn(hrdn_c),
      .flash(flash_c), .seg(seg_c), .an(an_c), .bcd(bcd_c),
      .busy(busy_c), .ovf(ovf_c));

   task automatic tick(input int n);
      repeat (n) @(posedge clk_19);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_a(input logic [4:0] t);
      int n = 0;
      while (an_a !== t && n < 100) begin tick(1); n++; end
      check("wait_an_a", {27'd0, an_a}, {27'd0, t});
   endtask

   task automatic wait_b(input logic [3:0] t);
      int n = 0;
      while (an_b !== t && n < 100) begin tick(1); n++; end
      check("wait_an_b", {28'd0, an_b}, {28'd0, t});
   endtask

   task automatic wait_c(input logic [1:0] t);
      int n = 0;
      while (an_c !== t && n < 300) begin tick(1); n++; end
      check("wait_an_c", {30'd0, an_c}, {30'd0, t});
   endtask

   logic [4:0] seq [6];

   initial begin
      seq = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
      rst = 1'b1;
      score_a = '0; score_b = '0; score_c = '0;
      hrdn_a = 4'hA; hrdn_b = 4'h0; hrdn_c = 4'h3;
      flash_a = 1'b0; flash_b = 1'b0; flash_c = 1'b0;

      // reset state
      tick(2);
      check("rst_an", an_a, 32'h1F);
      check("rst_seg", seg_a, 32'h7F);
      check("rst_bcd", bcd_a, 32'h0);
      check("rst_busy", busy_a, 32'h0);
      check("rst_ovf", ovf_a, 32'h0);
      rst = 1'b0;
      tick(1);
      check("pos0_an", an_a, 32'h1E);
      check("pos0_seg", seg_a, 32'h40);
      tick(3);
      check("zero_busy", busy_a, 32'h0);
      check("zero_bcd", bcd_a, 32'h0);
      wait_a(5'b11101);
      check("zero_d1", seg_a, 32'h7F);
      wait_a(5'b10111);
      check("zero_d3", seg_a, 32'h7F);

      // scan order, hold time, hardness glyph
      wait_a(5'b01111);
      check("hrdn_A", seg_a, 32'h08);
      wait_a(5'b11110);
      for (int s = 0; s < 6; s++) begin
         check("scan_first", an_a, {27'd0, seq[s]});
         tick(3);
         check("scan_hold", an_a, {27'd0, seq[s]});
         tick(1);
      end

      // 937 conversion latency and display
      score_a = 12'd937;
      tick(1);
      check("c937_busy1", busy_a, 32'h1);
      tick(12);
      check("c937_busy13", busy_a, 32'h1);
      tick(1);
      check("c937_busy", busy_a, 32'h0);
      check("c937_bcd", bcd_a, 32'h0937);
      check("c937_ovf", ovf_a, 32'h0);
      wait_a(5'b11110);
      check("c937_d0", seg_a, 32'h78);
      wait_a(5'b11101);
      check("c937_d1", seg_a, 32'h30);
      wait_a(5'b11011);
      check("c937_d2", seg_a, 32'h10);
      wait_a(5'b10111);
      check("c937_d3", seg_a, 32'h7F);

      // score change mid-conversion
      score_a = 12'd100;
      tick(3);
      score_a = 12'd200;
      tick(11);
      check("c100_bcd", bcd_a, 32'h0100);
      check("c100_busy", busy_a, 32'h0);
      tick(1);
      check("c200_busy", busy_a, 32'h1);
      tick(13);
      check("c200_bcd", bcd_a, 32'h0200);
      check("c200_busy0", busy_a, 32'h0);
      wait_a(5'b11011);
      check("c200_d2", seg_a, 32'h24);
      wait_a(5'b10111);
      check("c200_d3", seg_a, 32'h7F);

      // overflow on three digits
      score_b = 12'd4095;
      tick(14);
      check("ovf_bcd", bcd_b, 32'h999);
      check("ovf_flag", ovf_b, 32'h1);
      check("ovf_busy", busy_b, 32'h0);
      wait_b(4'b1011);
      check("ovf_d2", seg_b, 32'h10);
      wait_b(4'b0111);
      check("ovf_h0", seg_b, 32'h40);
      wait_b(4'b1110);
      check("ovf_d0", seg_b, 32'h10);
      wait_b(4'b1101);
      check("ovf_d1", seg_b, 32'h10);
      score_b = 12'd5;
      tick(14);
      check("c5_bcd", bcd_b, 32'h005);
      check("c5_ovf", ovf_b, 32'h0);
      wait_b(4'b1101);
      check("c5_d1", seg_b, 32'h7F);
      wait_b(4'b1110);
      check("c5_d0", seg_b, 32'h12);

      // hardness flash, retrigger, reset
      wait_c(2'b10);
      wait_c(2'b01);
      check("fl_lit", seg_c, 32'h30);
      flash_c = 1'b1;
      tick(1);
      check("fl_e1", seg_c, 32'h30);
      tick(1);
      check("fl_e2", seg_c, 32'h7F);
      tick(7);
      check("fl_e9", seg_c, 32'h7F);
      tick(1);
      check("fl_e10", seg_c, 32'h30);
      flash_c = 1'b0;
      tick(1);
      flash_c = 1'b1;
      tick(2);
      flash_c = 1'b0;
      tick(2);
      flash_c = 1'b1;
      tick(5);
      check("rt_e19", seg_c, 32'h7F);
      tick(1);
      check("rt_ext", seg_c, 32'h7F);
      tick(3);
      check("rt_e24", seg_c, 32'h7F);
      tick(1);
      check("rt_end", seg_c, 32'h30);
      flash_c = 1'b0;
      tick(1);
      flash_c = 1'b1;
      tick(2);
      check("rs_blank", seg_c, 32'h7F);
      tick(1);
      rst = 1'b1;
      flash_c = 1'b0;
      tick(1);
      check("rs_seg", seg_c, 32'h7F);
      check("rs_an", an_c, 32'h3);
      check("rs_bcd_a", bcd_a, 32'h0);
      rst = 1'b0;
      tick(1);
      check("rs_reconv", busy_a, 32'h1);
      wait_c(2'b01);
      check("rs_lit", seg_c, 32'h30);
      check("rs_bcd200", bcd_a, 32'h0200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
